// File: rtl/mem_bank_rw_pkg.sv
// Shared types and helpers for the mem_bank_rw storage bank and its write decoder.
package mem_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_DEPTH  = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } mem_bank_state_e;

  function automatic logic onehot_hit(input int unsigned sel, input int unsigned idx,
                                      input logic en);
    return en && (sel == idx);
  endfunction

endpackage

// File: rtl/mem_bank_rw_addr_decoder.sv
// Generalised one-hot write-select demux; all outputs low when en is low.
module addr_decoder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]    sel,
  input  logic                 en,
  output logic [2**ADDR_W-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < 2**ADDR_W; gi++) begin : g_dec
      assign onehot[gi] = onehot_hit(32'(sel), gi, en);
    end
  endgenerate

endmodule

// File: rtl/mem_bank_rw.sv
// DEPTH x WIDTH storage bank with valid/ready requests and a hardware clear sweep.
// Build option: MEM_BANK_OUT_REG_EN adds a second response register stage (read latency 2).
module mem_bank_rw
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [WIDTH-1:0]         req_wdata,
  output logic                     rsp_valid,
  output logic [WIDTH-1:0]         rsp_rdata,
  output logic                     busy
);

  localparam int ADDR_W = $clog2(DEPTH);
`ifdef MEM_BANK_OUT_REG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  mem_bank_state_e   r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W-1:0] w_dec_sel;
  logic              w_dec_en;
  logic [WIDTH-1:0]  w_wdata;
  logic [DEPTH-1:0]  w_onehot;
  logic              w_accept;
  logic              w_rd_acc;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [STAGES-1:0] r_vld_pipe;
  logic [WIDTH-1:0]  r_dat_pipe [STAGES];

  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state == CLEAR);
  assign w_accept  = req_valid && (r_state == IDLE);
  assign w_rd_acc  = w_accept && !req_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // The sweep shares the decoder: in CLEAR it steers zeros to r_ptr.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_dec_sel   = req_addr;
    w_dec_en    = w_accept && req_we;
    w_wdata     = req_wdata;
    case (r_state)
      CLEAR: begin
        w_dec_sel = r_ptr;
        w_dec_en  = 1'b1;
        w_wdata   = '0;
        if (clr) begin
          w_ptr_nxt = '0;
        end else begin
          w_ptr_nxt = r_ptr + 1'b1;
          if (r_ptr == ADDR_W'(DEPTH - 1)) w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        if (clr) begin
          w_state_nxt = CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      default: w_state_nxt = CLEAR;
    endcase
    if (rst) w_dec_en = 1'b0;
  end

  addr_decoder #(.ADDR_W(ADDR_W)) u_dec (
    .sel    (w_dec_sel),
    .en     (w_dec_en),
    .onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_onehot[i]) r_mem[i] <= w_wdata;
    end
  end

  // Data stages only load behind a valid, so rsp_rdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_pipe <= '0;
      for (int i = 0; i < STAGES; i++) r_dat_pipe[i] <= '0;
    end else begin
      r_vld_pipe[0] <= w_rd_acc;
      if (w_rd_acc) r_dat_pipe[0] <= r_mem[req_addr];
      for (int i = 1; i < STAGES; i++) begin
        r_vld_pipe[i] <= r_vld_pipe[i-1];
        if (r_vld_pipe[i-1]) r_dat_pipe[i] <= r_dat_pipe[i-1];
      end
    end
  end

  assign rsp_valid = r_vld_pipe[STAGES-1];
  assign rsp_rdata = r_dat_pipe[STAGES-1];

endmodule

// File: tb/tb_mem_bank_rw.sv
// Directed bench for mem_bank_rw: sweep timing, read/write, back-to-back, clr and rst corners.
module tb_mem_bank_rw;

`ifdef MEM_BANK_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, clr, req_valid, req_we;
  logic [2:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_rdata;

  logic        rst16, clr16, req_valid16, req_we16;
  logic [3:0]  req_addr16;
  logic [31:0] req_wdata16;
  logic        req_ready16, rsp_valid16, busy16;
  logic [31:0] rsp_rdata16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_bank_rw #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  mem_bank_rw #(.WIDTH(32), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst16), .clr(clr16),
    .req_valid(req_valid16), .req_ready(req_ready16), .req_we(req_we16),
    .req_addr(req_addr16), .req_wdata(req_wdata16),
    .rsp_valid(rsp_valid16), .rsp_rdata(rsp_rdata16), .busy(busy16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [2:0] a, input logic [15:0] e);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a;
    step();
    req_valid = 1'b0;
    for (int i = 1; i < LAT; i++) begin
      chk({tag, "_early"}, 64'(rsp_valid), 64'(1'b0));
      step();
    end
    chk({tag, "_v"}, 64'(rsp_valid), 64'(1'b1));
    chk({tag, "_d"}, 64'(rsp_rdata), 64'(e));
    step();
    chk({tag, "_drop"}, 64'(rsp_valid), 64'(1'b0));
  endtask

  // Expects state just after entering CLEAR at ptr 0; walks the full 8-cycle sweep.
  task automatic sweep8(input string tag);
    chk({tag, "_busy0"}, 64'(busy), 64'(1'b1));
    for (int i = 1; i < 8; i++) begin
      step();
      chk({tag, "_busy"}, 64'({busy, req_ready, rsp_valid}), 64'(3'b100));
    end
    step();
    chk({tag, "_done"}, 64'({busy, req_ready}), 64'(2'b01));
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rst16 = 1'b1; clr16 = 1'b0; req_valid16 = 1'b0; req_we16 = 1'b0;
    req_addr16 = '0; req_wdata16 = '0;

    // Reset values, then exactly 8 busy cycles
    step();
    chk("rst_busy",  64'(busy),      64'(1'b1));
    chk("rst_ready", 64'(req_ready), 64'(1'b0));
    chk("rst_vld",   64'(rsp_valid), 64'(1'b0));
    chk("rst_data",  64'(rsp_rdata), 64'(16'h0000));
    rst = 1'b0;
    sweep8("init");
    for (int a = 0; a < 8; a++) rd("init_zero", 3'(a), 16'h0000);

    // Write then read the next cycle
    wr(3'd3, 16'hBEEF);
    rd("raw3", 3'd3, 16'hBEEF);
    rd("rd4", 3'd4, 16'h0000);

    // Back-to-back reads
    for (int a = 0; a < 8; a++) wr(3'(a), 16'(16'h1111 * (a + 1)));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd0;
    for (int k = 0; k < 8 + LAT; k++) begin
      step();
      if (k < 7) req_addr = 3'(k + 1);
      else req_valid = 1'b0;
      if (k >= LAT - 1 && k - (LAT - 1) < 8) begin
        chk("b2b_v", 64'(rsp_valid), 64'(1'b1));
        chk("b2b_d", 64'(rsp_rdata), 64'(16'h1111 * (k - (LAT - 1) + 1)));
      end else if (k >= LAT - 1) begin
        chk("b2b_end_v", 64'(rsp_valid), 64'(1'b0));
        chk("b2b_hold",  64'(rsp_rdata), 64'(16'h8888));
      end
    end

    // clr together with an accepted read
    wr(3'd3, 16'hBEEF);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd3; clr = 1'b1;
    step();
    req_valid = 1'b0; clr = 1'b0;
    chk("clr_busy0", 64'(busy), 64'(1'b1));
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      chk("clr_busy", 64'(busy), 64'(1'b1));
      if (i == LAT - 1) begin
        chk("clr_rsp_v", 64'(rsp_valid), 64'(1'b1));
        chk("clr_rsp_d", 64'(rsp_rdata), 64'(16'hBEEF));
      end
    end
    step();
    chk("clr_done", 64'({busy, req_ready}), 64'(2'b01));
    rd("clr_rd3", 3'd3, 16'h0000);

    // rst at sweep cycle 4, with a request pending that must be ignored
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd2;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", 64'(rsp_valid), 64'(1'b0));
    sweep8("mid_rst");
    req_valid = 1'b0;

    // rst one cycle after a read is accepted cancels the response
    wr(3'd5, 16'hA5A5);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 3'd5;
    step();
    req_valid = 1'b0; rst = 1'b1;
    if (LAT == 1) chk("inflight_pre", 64'(rsp_data_pair()), 64'({1'b1, 16'hA5A5}));
    step();
    rst = 1'b0;
    chk("inflight_v", 64'(rsp_valid), 64'(1'b0));
    chk("inflight_d", 64'(rsp_rdata), 64'(16'h0000));
    step();
    chk("inflight_v2", 64'(rsp_valid), 64'(1'b0));
    for (int i = 0; i < 7; i++) step();
    chk("inflight_ready", 64'(req_ready), 64'(1'b1));
    rd("after_rst5", 3'd5, 16'h0000);

    // DEPTH=16, WIDTH=32 instance: 16-cycle sweep
    step();
    chk("d16_rst", 64'({busy16, req_ready16, rsp_valid16}), 64'(3'b100));
    chk("d16_rst_d", 64'(rsp_rdata16), 64'(32'h0));
    rst16 = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("d16_busy", 64'({busy16, req_ready16}), 64'(2'b10));
    end
    step();
    chk("d16_done", 64'({busy16, req_ready16}), 64'(2'b01));
    req_valid16 = 1'b1; req_we16 = 1'b1; req_addr16 = 4'd15; req_wdata16 = 32'hDEADBEEF;
    step();
    req_we16 = 1'b0;
    step();
    req_valid16 = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    chk("d16_rd_v", 64'(rsp_valid16), 64'(1'b1));
    chk("d16_rd_d", 64'(rsp_rdata16), 64'(32'hDEADBEEF));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic [16:0] rsp_data_pair();
    return {rsp_valid, rsp_rdata};
  endfunction

endmodule
